instruction_encoder: RTL and testbench

Streaming MIPS-subset instruction encoder, the inverse of the instruction decode stage. It accepts an operation code plus register, immediate and address fields over a valid/ready handshake. It packs them into 32-bit instruction words and buffers them in a small FIFO. It drains them toward instruction memory, each word tagged with its destination word address. Test benches and the program loader use it to produce instruction streams without hand-assembled hex.

---
 rtl/instruction_encoder.sv | 138 +++++++++++++
 tb/tb_instruction_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Streaming MIPS-subset encoder: packs op/field tuples into 32-bit words and
// queues them, each tagged with its instruction-memory word address.
module instruction_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic [4:0]                 in_rs,
    input  logic [4:0]                 in_rt,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_shamt,
    input  logic [15:0]                in_imm,
    input  logic [25:0]                in_adr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [ADDR_W-1:0]          out_addr,
    output logic                       illegal,
    output logic                       wrapped,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

    logic [31:0]       instrMem_q [DEPTH];
    logic [ADDR_W-1:0] addrMem_q  [DEPTH];
    logic [PW-1:0]     rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    logic [PW:0]       count_q, count_d;
    logic [ADDR_W-1:0] addrCnt_q, addrCnt_d;
    logic              illegal_q, illegal_d, wrapped_q, wrapped_d;

    logic [31:0] encWord;
    logic        opLegal, accept, push, pop;

    always_comb begin
        encWord = '0;
        opLegal = 1'b1;
        case (in_op)
            4'd0:    encWord = {6'h00, in_rs, in_rt, in_rd, in_shamt, 6'h20};
            4'd1:    encWord = {6'h00, in_rs, in_rt, in_rd, in_shamt, 6'h21};
            4'd2:    encWord = {6'h00, in_rs, in_rt, in_rd, in_shamt, 6'h22};
            4'd3:    encWord = {6'h00, in_rs, in_rt, in_rd, in_shamt, 6'h24};
            4'd4:    encWord = {6'h08, in_rs, in_rt, in_imm};
            4'd5:    encWord = {6'h23, in_rs, in_rt, in_imm};
            4'd6:    encWord = {6'h2B, in_rs, in_rt, in_imm};
            4'd7:    encWord = {6'h04, in_rs, in_rt, in_imm};
            4'd8:    encWord = {6'h02, in_adr};
            default: opLegal = 1'b0;
        endcase
    end

    assign in_ready  = (count_q != FULL_LVL);
    assign out_valid = (count_q != '0);
    assign accept    = in_valid & in_ready;
    // Illegal ops complete the handshake but never reach the queue.
    assign push      = accept & opLegal & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        rdPtr_d   = rdPtr_q;
        wrPtr_d   = wrPtr_q;
        count_d   = count_q;
        addrCnt_d = addrCnt_q;
        illegal_d = illegal_q;
        wrapped_d = wrapped_q;
        if (flush) begin
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            count_d   = '0;
            addrCnt_d = '0;
            illegal_d = 1'b0;
            wrapped_d = 1'b0;
        end else begin
            if (accept && !opLegal) begin
                illegal_d = 1'b1;
            end
            if (push) begin
                wrPtr_d   = wrPtr_q + PW'(1);
                addrCnt_d = addrCnt_q + ADDR_W'(1);
                if (addrCnt_q == '1) begin
                    wrapped_d = 1'b1;
                end
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
            addrCnt_q <= '0;
            illegal_q <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
            count_q   <= count_d;
            addrCnt_q <= addrCnt_d;
            illegal_q <= illegal_d;
            wrapped_q <= wrapped_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instrMem_q[i] <= '0;
                addrMem_q[i]  <= '0;
            end
        end else if (push) begin
            instrMem_q[wrPtr_q] <= encWord;
            addrMem_q[wrPtr_q]  <= addrCnt_q;
        end
    end

    // Head fields read as zero when empty so stale entries never show.
    assign out_instr = out_valid ? instrMem_q[rdPtr_q] : '0;
    assign out_addr  = out_valid ? addrMem_q[rdPtr_q]  : '0;
    assign illegal   = illegal_q;
    assign wrapped   = wrapped_q;
    assign level     = count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: an ADDR_W=8 and an ADDR_W=2
// instance share all inputs so address wrap is seen on the narrow one.
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        rst, flush, inValid, outReady;
    logic [3:0]  inOp;
    logic [4:0]  inRs, inRt, inRd, inShamt;
    logic [15:0] inImm;
    logic [25:0] inAdr;

    logic        inReady, outValid, illegalF, wrappedF;
    logic [31:0] outInstr;
    logic [7:0]  outAddr;
    logic [2:0]  level;

    logic        inReadyW, outValidW, illegalW, wrappedW;
    logic [31:0] outInstrW;
    logic [1:0]  outAddrW;
    logic [2:0]  levelW;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    instruction_encoder #(.ADDR_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(inReady), .in_op(inOp),
        .in_rs(inRs), .in_rt(inRt), .in_rd(inRd), .in_shamt(inShamt),
        .in_imm(inImm), .in_adr(inAdr),
        .out_valid(outValid), .out_ready(outReady), .out_instr(outInstr),
        .out_addr(outAddr), .illegal(illegalF), .wrapped(wrappedF), .level(level)
    );

    instruction_encoder #(.ADDR_W(2), .DEPTH(4)) dutW (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(inReadyW), .in_op(inOp),
        .in_rs(inRs), .in_rt(inRt), .in_rd(inRd), .in_shamt(inShamt),
        .in_imm(inImm), .in_adr(inAdr),
        .out_valid(outValidW), .out_ready(outReady), .out_instr(outInstrW),
        .out_addr(outAddrW), .illegal(illegalW), .wrapped(wrappedW), .level(levelW)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [4:0] sh,
                                 input logic [15:0] imm, input logic [25:0] adr);
        inValid = v; inOp = op; inRs = rs; inRt = rt; inRd = rd;
        inShamt = sh; inImm = imm; inAdr = adr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    endtask

    task automatic doFlush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    logic [31:0] bbWord [5];
    logic [31:0] addWord [6];

    initial begin
        bbWord[0] = 32'h20010005; bbWord[1] = 32'h8FA80004; bbWord[2] = 32'hAC050008;
        bbWord[3] = 32'h1022FFFF; bbWord[4] = 32'h08000010;
        addWord[0] = 32'h0; addWord[1] = 32'h00210820; addWord[2] = 32'h00421020;
        addWord[3] = 32'h00631820; addWord[4] = 32'h00842020; addWord[5] = 32'h00A52820;

        rst = 1'b1; flush = 1'b0; outReady = 1'b0;
        idle();
        step();
        step();
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_out_instr", outInstr, 32'd0);
        checkOutput("rst_out_addr", 32'(outAddr), 32'd0);
        checkOutput("rst_illegal", 32'(illegalF), 32'd0);
        checkOutput("rst_wrapped", 32'(wrappedF), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_in_ready", 32'(inReady), 32'd1);
        rst = 1'b0;
        step();

        // Single add, visible the cycle after acceptance
        applyStimulus(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        checkOutput("add_pre_valid", 32'(outValid), 32'd0);
        step();
        idle();
        checkOutput("add_valid", 32'(outValid), 32'd1);
        checkOutput("add_instr", outInstr, 32'h00221820);
        checkOutput("add_addr", 32'(outAddr), 32'd0);
        step();
        checkOutput("add_hold_instr", outInstr, 32'h00221820);
        outReady = 1'b1;
        step();
        checkOutput("add_drained", 32'(level), 32'd0);

        // Back-to-back I/J words with the consumer always ready
        doFlush();
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: applyStimulus(1'b1, 4'd4, 5'd0, 5'd1, 5'd7, 5'd3, 16'h0005, 26'h0);
                1: applyStimulus(1'b1, 4'd5, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
                2: applyStimulus(1'b1, 4'd6, 5'd0, 5'd5, 5'd0, 5'd0, 16'h0008, 26'h0);
                3: applyStimulus(1'b1, 4'd7, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
                default: applyStimulus(1'b1, 4'd8, 5'd9, 5'd9, 5'd9, 5'd9, 16'h1234, 26'h10);
            endcase
            step();
            checkOutput($sformatf("bb_instr%0d", k), outInstr, bbWord[k]);
            checkOutput($sformatf("bb_addr%0d", k), 32'(outAddr), 32'(k));
            checkOutput($sformatf("bb_level%0d", k), 32'(level), 32'd1);
            checkOutput($sformatf("bbW_addr%0d", k), 32'(outAddrW), 32'(k % 4));
            if (k == 2) checkOutput("bbW_nowrap", 32'(wrappedW), 32'd0);
        end
        idle();
        step();
        checkOutput("bb_level_end", 32'(level), 32'd0);
        checkOutput("bbW_wrapped", 32'(wrappedW), 32'd1);
        checkOutput("bb_no_wrap", 32'(wrappedF), 32'd0);

        // Fill to DEPTH with consumer stalled, then one pop releases a stalled word
        doFlush();
        checkOutput("flush_clr_wrapW", 32'(wrappedW), 32'd0);
        outReady = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 4'd0, 5'(k), 5'(k), 5'(k), 5'd0, 16'h0, 26'h0);
            step();
            checkOutput($sformatf("fill_level%0d", k), 32'(level), 32'(k));
        end
        checkOutput("full_in_ready", 32'(inReady), 32'd0);
        applyStimulus(1'b1, 4'd0, 5'd5, 5'd5, 5'd5, 5'd0, 16'h0, 26'h0);
        step();
        checkOutput("stall_level", 32'(level), 32'd4);
        checkOutput("stall_head", outInstr, addWord[1]);
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        checkOutput("pop_level", 32'(level), 32'd3);
        checkOutput("pop_in_ready", 32'(inReady), 32'd1);
        step();
        idle();
        checkOutput("refill_level", 32'(level), 32'd4);
        outReady = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            checkOutput($sformatf("drain_instr%0d", k), outInstr, addWord[k]);
            checkOutput($sformatf("drain_addr%0d", k), 32'(outAddr), 32'(k - 1));
            step();
        end
        checkOutput("drain_empty", 32'(outValid), 32'd0);

        // Illegal op between two adds
        doFlush();
        applyStimulus(1'b1, 4'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
        step();
        checkOutput("ill_first_addr", 32'(outAddr), 32'd0);
        applyStimulus(1'b1, 4'd12, 5'd3, 5'd3, 5'd3, 5'd0, 16'h0, 26'h0);
        step();
        checkOutput("ill_flag", 32'(illegalF), 32'd1);
        checkOutput("ill_nothing_queued", 32'(outValid), 32'd0);
        applyStimulus(1'b1, 4'd0, 5'd2, 5'd2, 5'd2, 5'd0, 16'h0, 26'h0);
        step();
        idle();
        checkOutput("ill_second_instr", outInstr, addWord[2]);
        checkOutput("ill_second_addr", 32'(outAddr), 32'd1);
        checkOutput("ill_sticky", 32'(illegalF), 32'd1);
        step();
        checkOutput("ill_only_two", 32'(level), 32'd0);

        // Flush concurrent with a push on a non-empty queue
        outReady = 1'b0;
        applyStimulus(1'b1, 4'd0, 5'd3, 5'd3, 5'd3, 5'd0, 16'h0, 26'h0);
        step();
        step();
        checkOutput("pre_flush_level", 32'(level), 32'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        checkOutput("flush_level", 32'(level), 32'd0);
        checkOutput("flush_valid", 32'(outValid), 32'd0);
        checkOutput("flush_illegal", 32'(illegalF), 32'd0);
        checkOutput("flush_in_ready", 32'(inReady), 32'd1);
        applyStimulus(1'b1, 4'd0, 5'd4, 5'd4, 5'd4, 5'd0, 16'h0, 26'h0);
        step();
        idle();
        checkOutput("post_flush_instr", outInstr, addWord[4]);
        checkOutput("post_flush_addr", 32'(outAddr), 32'd0);

        // Asynchronous reset mid-stream with three entries queued
        applyStimulus(1'b1, 4'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
        step();
        step();
        idle();
        checkOutput("pre_rst_level", 32'(level), 32'd3);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_level", 32'(level), 32'd0);
        checkOutput("arst_valid", 32'(outValid), 32'd0);
        checkOutput("arst_in_ready", 32'(inReady), 32'd1);
        step();
        rst = 1'b0;
        step();
        checkOutput("arst_release_valid", 32'(outValid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
